// File: rtl/id_ex_latch.sv
// ID/EX pipeline register with stall, flush (bubble) and synchronous reset.
// Optional rs-field forwarding path enabled by defining ID_EX_RS_FIELD_EN.
module id_ex_latch #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             valid_in,
  input  logic [1:0]       ctlwb_in,
  input  logic [2:0]       ctlm_in,
  input  logic [3:0]       ctlex_in,
  input  logic [WIDTH-1:0] npc_in,
  input  logic [WIDTH-1:0] readdat1_in,
  input  logic [WIDTH-1:0] readdat2_in,
  input  logic [WIDTH-1:0] signext_in,
  input  logic [4:0]       instr_2016_in,
  input  logic [4:0]       instr_1511_in,
`ifdef ID_EX_RS_FIELD_EN
  input  logic [4:0]       instr_2521_in,
  output logic [4:0]       instr_2521_out,
`endif
  output logic [1:0]       wb_out,
  output logic [2:0]       m_out,
  output logic             regdst_out,
  output logic [1:0]       aluop_out,
  output logic             alusrc_out,
  output logic [WIDTH-1:0] npc_out,
  output logic [WIDTH-1:0] readdat1_out,
  output logic [WIDTH-1:0] readdat2_out,
  output logic [WIDTH-1:0] signext_out,
  output logic [4:0]       instr_2016_out,
  output logic [4:0]       instr_1511_out,
  output logic [5:0]       funct_out,
  output logic             valid_out
);

  logic [1:0]       wb_q, wb_d;
  logic [2:0]       m_q, m_d;
  logic [3:0]       ex_q, ex_d;
  logic [WIDTH-1:0] npc_q, npc_d;
  logic [WIDTH-1:0] rd1_q, rd1_d;
  logic [WIDTH-1:0] rd2_q, rd2_d;
  logic [WIDTH-1:0] sext_q, sext_d;
  logic [4:0]       rt_q, rt_d;
  logic [4:0]       rd_q, rd_d;
  logic [4:0]       rs_q, rs_d;
  logic             valid_q, valid_d;
  logic [4:0]       rs_in;

`ifdef ID_EX_RS_FIELD_EN
  assign rs_in = instr_2521_in;
`else
  assign rs_in = 5'd0;
`endif

  // Flush outranks stall so a stalled stage can still be turned into a bubble.
  always_comb begin
    wb_d    = wb_q;
    m_d     = m_q;
    ex_d    = ex_q;
    npc_d   = npc_q;
    rd1_d   = rd1_q;
    rd2_d   = rd2_q;
    sext_d  = sext_q;
    rt_d    = rt_q;
    rd_d    = rd_q;
    rs_d    = rs_q;
    valid_d = valid_q;
    if (flush) begin
      wb_d    = '0;
      m_d     = '0;
      ex_d    = '0;
      npc_d   = '0;
      rd1_d   = '0;
      rd2_d   = '0;
      sext_d  = '0;
      rt_d    = '0;
      rd_d    = '0;
      rs_d    = '0;
      valid_d = 1'b0;
    end else if (!stall) begin
      wb_d    = ctlwb_in;
      m_d     = ctlm_in;
      ex_d    = ctlex_in;
      npc_d   = npc_in;
      rd1_d   = readdat1_in;
      rd2_d   = readdat2_in;
      sext_d  = signext_in;
      rt_d    = instr_2016_in;
      rd_d    = instr_1511_in;
      rs_d    = rs_in;
      valid_d = valid_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_q    <= '0;
      m_q     <= '0;
      ex_q    <= '0;
      npc_q   <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      sext_q  <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
      rs_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      wb_q    <= wb_d;
      m_q     <= m_d;
      ex_q    <= ex_d;
      npc_q   <= npc_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      sext_q  <= sext_d;
      rt_q    <= rt_d;
      rd_q    <= rd_d;
      rs_q    <= rs_d;
      valid_q <= valid_d;
    end
  end

  assign wb_out         = wb_q;
  assign m_out          = m_q;
  assign regdst_out     = ex_q[3];
  assign aluop_out      = ex_q[2:1];
  assign alusrc_out     = ex_q[0];
  assign npc_out        = npc_q;
  assign readdat1_out   = rd1_q;
  assign readdat2_out   = rd2_q;
  assign signext_out    = sext_q;
  assign instr_2016_out = rt_q;
  assign instr_1511_out = rd_q;
  assign funct_out      = sext_q[5:0];
  assign valid_out      = valid_q;
`ifdef ID_EX_RS_FIELD_EN
  assign instr_2521_out = rs_q;
`else
  // rs register is unused in this build; keep lint quiet about it.
  logic unused_rs;
  assign unused_rs = ^rs_q;
`endif

endmodule

// File: tb/tb_id_ex_latch.sv
// Self-checking bench for id_ex_latch: directed vector table, corner sequences,
// and randomized traffic against a one-stage behavioural model.
module tb_id_ex_latch;
  localparam int W = 32;
`ifdef ID_EX_RS_FIELD_EN
  localparam bit RsEn = 1'b1;
`else
  localparam bit RsEn = 1'b0;
`endif

  typedef struct packed {
    logic         rst, stall, flush, valid;
    logic [1:0]   wb;
    logic [2:0]   m;
    logic [3:0]   ex;
    logic [W-1:0] npc, rd1, rd2, sext;
    logic [4:0]   rt, rd, rs;
  } in_t;

  typedef struct packed {
    logic [1:0]   wb;
    logic [2:0]   m;
    logic         regdst;
    logic [1:0]   aluop;
    logic         alusrc;
    logic [W-1:0] npc, rd1, rd2, sext;
    logic [4:0]   rt, rd, rs;
    logic [5:0]   funct;
    logic         valid;
  } out_t;

  typedef struct {
    in_t  in;
    out_t exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst, stall, flush, valid_in;
  logic [1:0] ctlwb_in;
  logic [2:0] ctlm_in;
  logic [3:0] ctlex_in;
  logic [W-1:0] npc_in, readdat1_in, readdat2_in, signext_in;
  logic [4:0] instr_2016_in, instr_1511_in, instr_2521_in;
  logic [1:0] wb_out;
  logic [2:0] m_out;
  logic regdst_out, alusrc_out, valid_out;
  logic [1:0] aluop_out;
  logic [W-1:0] npc_out, readdat1_out, readdat2_out, signext_out;
  logic [4:0] instr_2016_out, instr_1511_out, rs_obs;
  logic [5:0] funct_out;

  int n_cmp = 0;
  int n_bad = 0;
  out_t model;
  out_t act;

  always #5 clk = ~clk;

  id_ex_latch #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_in(valid_in),
    .ctlwb_in(ctlwb_in), .ctlm_in(ctlm_in), .ctlex_in(ctlex_in),
    .npc_in(npc_in), .readdat1_in(readdat1_in), .readdat2_in(readdat2_in),
    .signext_in(signext_in), .instr_2016_in(instr_2016_in), .instr_1511_in(instr_1511_in),
`ifdef ID_EX_RS_FIELD_EN
    .instr_2521_in(instr_2521_in), .instr_2521_out(rs_obs),
`endif
    .wb_out(wb_out), .m_out(m_out), .regdst_out(regdst_out), .aluop_out(aluop_out),
    .alusrc_out(alusrc_out), .npc_out(npc_out), .readdat1_out(readdat1_out),
    .readdat2_out(readdat2_out), .signext_out(signext_out),
    .instr_2016_out(instr_2016_out), .instr_1511_out(instr_1511_out),
    .funct_out(funct_out), .valid_out(valid_out)
  );

`ifndef ID_EX_RS_FIELD_EN
  assign rs_obs = 5'd0;
`endif

  assign act = {wb_out, m_out, regdst_out, aluop_out, alusrc_out, npc_out, readdat1_out,
                readdat2_out, signext_out, instr_2016_out, instr_1511_out, rs_obs,
                funct_out, valid_out};

  function automatic in_t mk_in(logic r, logic s, logic f, logic v, logic [1:0] wb,
                                logic [2:0] m, logic [3:0] ex, logic [W-1:0] npc,
                                logic [W-1:0] rd1, logic [W-1:0] rd2, logic [W-1:0] sext,
                                logic [4:0] rt, logic [4:0] rd, logic [4:0] rs);
    in_t i;
    i.rst = r; i.stall = s; i.flush = f; i.valid = v;
    i.wb = wb; i.m = m; i.ex = ex; i.npc = npc; i.rd1 = rd1; i.rd2 = rd2;
    i.sext = sext; i.rt = rt; i.rd = rd; i.rs = rs;
    return i;
  endfunction

  function automatic out_t mk_out(logic [1:0] wb, logic [2:0] m, logic [3:0] ex,
                                  logic [W-1:0] npc, logic [W-1:0] rd1, logic [W-1:0] rd2,
                                  logic [W-1:0] sext, logic [4:0] rt, logic [4:0] rd,
                                  logic [4:0] rs, logic v);
    out_t o;
    o.wb = wb; o.m = m;
    o.regdst = ex[3]; o.aluop = ex[2:1]; o.alusrc = ex[0];
    o.npc = npc; o.rd1 = rd1; o.rd2 = rd2; o.sext = sext;
    o.rt = rt; o.rd = rd; o.rs = RsEn ? rs : 5'd0;
    o.funct = sext[5:0]; o.valid = v;
    return o;
  endfunction

  // Reference: the stage holds whatever the priority rule says it should hold.
  task automatic apply(input in_t v);
    rst = v.rst; stall = v.stall; flush = v.flush; valid_in = v.valid;
    ctlwb_in = v.wb; ctlm_in = v.m; ctlex_in = v.ex; npc_in = v.npc;
    readdat1_in = v.rd1; readdat2_in = v.rd2; signext_in = v.sext;
    instr_2016_in = v.rt; instr_1511_in = v.rd; instr_2521_in = v.rs;
    if (v.rst || v.flush) model = '0;
    else if (!v.stall)
      model = mk_out(v.wb, v.m, v.ex, v.npc, v.rd1, v.rd2, v.sext, v.rt, v.rd, v.rs, v.valid);
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input out_t a, input out_t e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endtask

  vec_t tbl[13];
  logic [5:0] fseq[5];
  in_t  cur;

  initial begin
    model = '0;
    apply(mk_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    tbl[0].in  = mk_in(1, 0, 0, 1, 2'b11, 3'b111, 4'b1101, 32'hFFFF_FFFC, 32'hAAAA_5555,
                       32'h5555_AAAA, 32'h0000_FFFF, 5'd31, 5'd30, 5'd29);
    tbl[0].exp = '0;
    tbl[1]     = tbl[0];
    tbl[2].in  = mk_in(0, 0, 0, 1, 2'b11, 3'b010, 4'b1100, 32'h100, 32'hDEAD_BEEF,
                       32'hCAFE_F00D, 32'h20, 5'd3, 5'd7, 5'd9);
    tbl[2].exp = mk_out(2'b11, 3'b010, 4'b1100, 32'h100, 32'hDEAD_BEEF, 32'hCAFE_F00D,
                        32'h20, 5'd3, 5'd7, 5'd9, 1'b1);
    for (int k = 3; k < 6; k++) begin
      tbl[k].in  = mk_in(0, 1, 0, 1, 2'b11, 3'b010, 4'b1100, 32'h104, 32'h1234_5678,
                         32'h1, 32'h22, 5'd4, 5'd8, 5'd10);
      tbl[k].exp = tbl[2].exp;
    end
    tbl[6].in  = mk_in(0, 0, 0, 1, 2'b11, 3'b010, 4'b1100, 32'h104, 32'h1234_5678,
                       32'h1, 32'h22, 5'd4, 5'd8, 5'd10);
    tbl[6].exp = mk_out(2'b11, 3'b010, 4'b1100, 32'h104, 32'h1234_5678, 32'h1, 32'h22,
                        5'd4, 5'd8, 5'd10, 1'b1);
    tbl[7].in  = mk_in(0, 1, 1, 1, 2'b11, 3'b010, 4'b1100, 32'h108, 32'h77, 32'h88,
                       32'h24, 5'd5, 5'd9, 5'd11);
    tbl[7].exp = '0;
    fseq[0] = 6'b100000; fseq[1] = 6'b100010; fseq[2] = 6'b100100;
    fseq[3] = 6'b100101; fseq[4] = 6'b101010;
    for (int k = 0; k < 5; k++) begin
      tbl[8+k].in  = mk_in(0, 0, 0, 1, 2'b10, 3'b000, 4'b1100, 32'h200 + k, 32'h0, 32'h0,
                           {26'd0, fseq[k]}, 5'd1, 5'd2, 5'd3);
      tbl[8+k].exp = mk_out(2'b10, 3'b000, 4'b1100, 32'h200 + k, 32'h0, 32'h0,
                            {26'd0, fseq[k]}, 5'd1, 5'd2, 5'd3, 1'b1);
    end

    for (int k = 0; k < 13; k++) begin
      apply(tbl[k].in);
      check($sformatf("vec%0d", k), act, tbl[k].exp);
    end
    n_cmp++;
    if (funct_out !== 6'b101010 || aluop_out !== 2'b10) begin
      n_bad++;
      $display("FAIL alu_feed: got funct %b aluop %b want 101010 10", funct_out, aluop_out);
    end

    // Bubble marked only by valid: controls still captured.
    apply(mk_in(0, 0, 0, 0, 2'b01, 3'b101, 4'b0111, 32'h300, 32'h5, 32'h6, 32'hFFFF_FFE7,
                5'd12, 5'd13, 5'd14));
    check("invalid_capture", act, mk_out(2'b01, 3'b101, 4'b0111, 32'h300, 32'h5, 32'h6,
                                         32'hFFFF_FFE7, 5'd12, 5'd13, 5'd14, 1'b0));

    // Long stall must not drift.
    cur = mk_in(0, 1, 0, 1, 2'b11, 3'b111, 4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31, 5'd31, 5'd31);
    for (int k = 0; k < 40; k++) begin
      apply(cur);
      check($sformatf("long_stall%0d", k), act, model);
    end

    // Reset during a stall wins, then loading resumes on the next edge.
    cur.rst = 1'b1;
    apply(cur);
    check("rst_mid_stall", act, '0);
    cur.rst = 1'b0; cur.stall = 1'b0;
    apply(cur);
    check("resume_after_rst", act, mk_out(2'b11, 3'b111, 4'b1111, 32'hFFFF_FFFF,
                                          32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                          5'd31, 5'd31, 5'd31, 1'b1));

`ifdef ID_EX_RS_FIELD_EN
    apply(mk_in(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd9));
    n_cmp++;
    if (rs_obs !== 5'd9) begin
      n_bad++;
      $display("FAIL rs_load: got %0d want 9", rs_obs);
    end
    apply(mk_in(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd9));
    n_cmp++;
    if (rs_obs !== 5'd0) begin
      n_bad++;
      $display("FAIL rs_flush: got %0d want 0", rs_obs);
    end
`endif

    for (int k = 0; k < 400; k++) begin
      cur.rst   = ($urandom_range(19) == 0);
      cur.flush = ($urandom_range(7) == 0);
      cur.stall = ($urandom_range(3) == 0);
      cur.valid = 1'($urandom);
      cur.wb    = 2'($urandom);
      cur.m     = 3'($urandom);
      cur.ex    = 4'($urandom);
      cur.npc   = $urandom;
      cur.rd1   = $urandom;
      cur.rd2   = $urandom;
      cur.sext  = $urandom;
      cur.rt    = 5'($urandom);
      cur.rd    = 5'($urandom);
      cur.rs    = 5'($urandom);
      apply(cur);
      check($sformatf("rand%0d", k), act, model);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
